// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the divider's sequencing states.
package alu_pkg;

  localparam int DIV_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor, keep or restore.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift_rem;
  logic [WIDTH:0] w_diff;

  // rem < divisor on entry, so a clear top bit of the difference means it is non-negative.
  assign w_shift_rem = {i_rem, i_quo[WIDTH-1]};
  assign w_diff      = w_shift_rem - {1'b0, i_divisor};

  always_comb begin
    if (w_diff[WIDTH]) begin
      o_rem = w_shift_rem[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end else begin
      o_rem = w_diff[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider (IDLE -> RUN for WIDTH cycles -> DONE, handshaked in and out).
// Define SEQ_DIVIDER_SIGNED_EN to honour is_signed with sign-magnitude correction.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       r_state, w_next_state;
  logic [WIDTH-1:0] r_rem, r_quo, r_divisor;
  logic [WIDTH-1:0] w_step_rem, w_step_quo, w_fin_rem, w_fin_quo;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [CNT_W-1:0] r_count;
  logic             r_dbz;
  logic             w_accept, w_last, w_dvs_zero;

  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_dvs_zero = (divisor == '0);
  assign w_last     = (r_count == CNT_W'(WIDTH - 1));

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_neg_q, r_neg_r;
  logic w_dvd_neg, w_dvs_neg;

  assign w_dvd_neg = is_signed && dividend[WIDTH-1];
  assign w_dvs_neg = is_signed && divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;
  // Quotient negated on sign mismatch; remainder follows the dividend. MIN/-1 wraps back to MIN.
  assign w_fin_quo = r_neg_q ? -w_step_quo : w_step_quo;
  assign w_fin_rem = r_neg_r ? -w_step_rem : w_step_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end
`else
  logic w_unused_is_signed;

  assign w_unused_is_signed = is_signed;
  assign w_dvd_mag          = dividend;
  assign w_dvs_mag          = divisor;
  assign w_fin_quo          = w_step_quo;
  assign w_fin_rem          = w_step_rem;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_divisor),
    .o_rem    (w_step_rem),
    .o_quo    (w_step_quo)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block is given a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = w_dvs_zero ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_dbz     <= 1'b0;
    end else if (w_accept) begin
      r_count   <= '0;
      r_divisor <= w_dvs_mag;
      if (w_dvs_zero) begin
        r_quo <= '1;
        r_rem <= dividend;
        r_dbz <= 1'b1;
      end else begin
        r_quo <= w_dvd_mag;
        r_rem <= '0;
        r_dbz <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_count <= r_count + CNT_W'(1);
      r_quo   <= w_last ? w_fin_quo : w_step_quo;
      r_rem   <= w_last ? w_fin_rem : w_step_rem;
    end
  end

  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, handshake/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_seq_divider;

  localparam int W = 64;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .is_signed  (is_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, C-style truncation for signed operands.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                output logic [63:0] q, output logic [63:0] r, output logic dz);
    longint sa, sb;
    dz = 1'b0;
    if (b == 64'd0) begin
      q  = ONES;
      r  = a;
      dz = 1'b1;
    end else if (SIGNED_EN && s) begin
      if (a == MINV && b == ONES) begin
        q = MINV;
        r = 64'd0;
      end else begin
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Entered and left at a negedge. lat counts rising edges from the accepting edge (inclusive)
  // up to the one after which out_valid is first seen high.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        output logic [63:0] q, output logic [63:0] r, output logic dz,
                        output int lat);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid  = 1'b0;
    dividend  = {$urandom, $urandom};
    divisor   = {$urandom, $urandom};
    is_signed = 1'($urandom);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    q = quotient;
    r = remainder;
    dz = div_by_zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] q, r, eq, er;
    logic        dz, edz;
    int          lat, g;
    logic [63:0] a, b;
    logic        s;
    bit          seen;

    vecs.push_back('{64'd100,    64'd7,  1'b0, 64'd14,   64'd2,      1'b0, 65});
    vecs.push_back('{64'h1234,   64'd0,  1'b0, ONES,     64'h1234,   1'b1,  1});
    vecs.push_back('{ONES,       64'd1,  1'b0, ONES,     64'd0,      1'b0, 65});
    vecs.push_back('{ONES,       ONES,   1'b0, 64'd1,    64'd0,      1'b0, 65});
    vecs.push_back('{64'd0,      64'd5,  1'b0, 64'd0,    64'd0,      1'b0, 65});
    vecs.push_back('{64'd5,      64'd10, 1'b0, 64'd0,    64'd5,      1'b0, 65});
    vecs.push_back('{MINV,       64'd3,  1'b0, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 65});
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0, 65});
    vecs.push_back('{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 65});
    vecs.push_back('{MINV, ONES, 1'b1, MINV, 64'd0, 1'b0, 65});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1,
                     ONES, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, lat);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), 64'(dz), 64'(vecs[i].dz));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Back-pressure in DONE: 1000/10 held for 10 cycles with stray operands on the inputs
    in_valid = 1'b1;
    dividend = 64'd1000;
    divisor  = 64'd10;
    is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("run_busy", 64'(busy), 64'd1);
    check("run_in_ready", 64'(in_ready), 64'd0);
    g = 1;
    while (!out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("stall_latency", 64'(g), 64'd65);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = {$urandom, $urandom};
      divisor  = {$urandom, $urandom};
      @(negedge clk);
      check($sformatf("stall%0d_quotient", i), quotient, 64'd100);
      check($sformatf("stall%0d_remainder", i), remainder, 64'd0);
      check($sformatf("stall%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("handshake_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready", 64'(in_ready), 64'd1);
    check("post_hs_out_valid", 64'(out_valid), 64'd0);

    // Reset while holding a divide-by-zero result in DONE
    in_valid = 1'b1;
    dividend = 64'h55;
    divisor  = 64'd0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("dz_hold_dbz", 64'(div_by_zero), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", 64'(out_valid), 64'd0);
    check("rst_done_dbz", 64'(div_by_zero), 64'd0);
    check("rst_done_remainder", remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset pulsed at RUN cycle 30
    in_valid = 1'b1;
    dividend = 64'd123456789;
    divisor  = 64'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("run30_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_run_busy", 64'(busy), 64'd0);
    check("rst_run_out_valid", 64'(out_valid), 64'd0);
    check("rst_run_quotient", quotient, 64'd0);
    check("rst_run_remainder", remainder, 64'd0);
    check("rst_run_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("no_stale_result", 64'(seen), 64'd0);
    run_op(64'd9, 64'd3, 1'b0, q, r, dz, lat);
    check("post_rst_quotient", q, 64'd3);
    check("post_rst_remainder", r, 64'd0);
    check("post_rst_latency", 64'(lat), 64'd65);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       b = 64'd0;
        1, 2:    b = 64'($urandom_range(1, 15));
        3, 4:    b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      s = 1'($urandom);
      model(a, b, s, eq, er, edz);
      run_op(a, b, s, q, r, dz, lat);
      check($sformatf("rnd%0d_quotient", n), q, eq);
      check($sformatf("rnd%0d_remainder", n), r, er);
      check($sformatf("rnd%0d_dbz", n), 64'(dz), 64'(edz));
      check($sformatf("rnd%0d_latency", n), 64'(lat), edz ? 64'd1 : 64'd65);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand/result width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands present.
REQ-005 SHALL have port in_ready  output  1  divider can accept operands.
REQ-006 SHALL have ports dividend and divisor  input  WIDTH  operands.
REQ-007 SHALL have port is_signed  input  1  signed-op request, sampled with operands.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have ports quotient and remainder  output  WIDTH  results.
REQ-011 SHALL have port div_by_zero  output  1  the held result came from divisor==0.
REQ-012 SHALL have port busy  output  1  high in RUN.

Function
REQ-013 SHALL implement a restoring shift/subtract divider with states IDLE, RUN, DONE, retiring one quotient bit per RUN cycle.
REQ-014 SHALL assert in_ready only in IDLE; accept when in_valid&&in_ready at a clock edge, latch operands, and go IDLE->RUN.
REQ-015 SHALL hold RUN for exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 edges after the accepting edge.
REQ-016 SHALL each RUN cycle shift {rem,quo} left by one, trial-subtract divisor from rem (WIDTH+1-bit), keep the difference and set quo bit 0 when non-negative, else restore.
REQ-017 SHALL hold quotient, remainder, div_by_zero and out_valid stable in DONE until out_valid&&out_ready, then go to IDLE on that edge.
REQ-018 SHALL, for divisor==0, skip RUN, go IDLE->DONE, return quotient all ones, remainder = dividend, div_by_zero=1 (out_valid one edge after accept).
REQ-019 SHALL ignore in_valid and operand changes outside IDLE; in_ready stays low in RUN and DONE, including the DONE handshake cycle.
REQ-020 SHALL clear div_by_zero on the next accept.

Reset
REQ-021 SHALL on rst_n low, immediately and regardless of state: state=IDLE, in_ready=1 after release, out_valid=0, busy=0, quotient=0, remainder=0, div_by_zero=0.
REQ-022 SHALL discard any in-flight operation when reset asserts mid-RUN or in DONE; no result is emitted after release.

Configuration
REQ-023 SHALL use macro SEQ_DIVIDER_SIGNED_EN.
REQ-024 SHALL with the macro defined honour is_signed=1: divide magnitudes, negate quotient when operand signs differ, give remainder the dividend's sign; MIN/-1 returns quotient=MIN, remainder=0; divide-by-zero per REQ-018.
REQ-025 SHALL without the macro ignore is_signed and perform unsigned division only, with no sign-correction logic synthesised.

Structure
REQ-026 SHALL take the WIDTH default constant and the IDLE/RUN/DONE state typedef from shared package alu_pkg.
REQ-027 SHALL place the single trial-subtract/restore step in combinational sub-module div_step (inputs rem, quo, divisor; outputs next rem, next quo).

Verification
REQ-028 SHALL cover: dividend=100, divisor=7 unsigned -> quotient=14, remainder=2, out_valid exactly 65 cycles after accept (WIDTH=64).
REQ-029 SHALL cover: dividend=0x1234, divisor=0 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_by_zero=1, out_valid 1 cycle after accept.
REQ-030 SHALL cover: dividend=0xFFFF_FFFF_FFFF_FFFF, divisor=1 -> quotient=all ones, remainder=0; divisor=dividend -> quotient=1, remainder=0.
REQ-031 SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0; handshake -> IDLE next edge, in_ready=1.
REQ-032 SHALL cover: rst_n pulsed low at RUN cycle 30 -> all outputs 0 at once; new 9/3 after release -> quotient=3, remainder=0.
REQ-033 SHALL cover (macro defined): -7/2 signed -> quotient=-3, remainder=-1; 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0.
